// File: rtl/uart_mem_bridge_pkg.sv
// uart_mem_bridge_pkg: opcodes, response bytes and FSM states shared by the bridge
package uart_mem_bridge_pkg;
  localparam logic [7:0] OP_READ  = 8'h01;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_FILL  = 8'h03;
  localparam logic [7:0] OP_PING  = 8'h04;
  localparam logic [7:0] RSP_ACK  = 8'hA5;
  localparam logic [7:0] RSP_PONG = 8'h5A;
  localparam logic [7:0] RSP_NAK  = 8'hEE;
  typedef enum logic [2:0] {IDLE, HDR, RD_ISSUE, RD_WAIT, RD_SEND, WR_DATA, FILL_RUN, RESP} state_e;
  function automatic logic [7:0] resp_byte(input logic [7:0] op);
    return op == OP_PING ? RSP_PONG : (op == OP_WRITE || op == OP_FILL) ? RSP_ACK : RSP_NAK;
  endfunction
endpackage

// File: rtl/uart_mem_bridge_timeout.sv
// uart_mem_bridge_timeout: idle down-counter reloaded on clr or while disabled; expired after TIMEOUT_CYCLES enabled idle cycles
// ports: clk, rst_n, en (count), clr (reload on received strobe), expired (0 when TIMEOUT_CYCLES==0)
module uart_mem_bridge_timeout #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expired
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = (!en || clr) ? LOAD : (cnt_q != '0 ? cnt_q - CW'(1) : cnt_q);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= LOAD;
    else cnt_q <= cnt_d;
  assign expired = (TIMEOUT_CYCLES != 0) && en && cnt_q == '0;
endmodule

// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge: framed UART command parser driving a synchronous memory port (READ/WRITE/FILL/PING)
// ports: clk, rst_n; UART rx (received, rx_byte) and tx (is_transmitting, transmit, tx_byte);
// memory (mem_read, mem_write, mem_addr, mem_wdata, mem_rdata); status (busy, error)
module uart_mem_bridge
  import uart_mem_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 16,
  parameter int MEM_LATENCY    = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  received,
  input  logic [7:0]            rx_byte,
  input  logic                  is_transmitting,
  output logic                  transmit,
  output logic [7:0]            tx_byte,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic                  busy,
  output logic                  error
);
  localparam int AW = ADDR_WIDTH;
  localparam int ADDR_BYTES = ADDR_WIDTH / 8;
  localparam logic [2:0] HDR_LEN = 3'(ADDR_BYTES + 1);
  localparam logic [1:0] LAT_END = 2'(MEM_LATENCY - 1);
  state_e state_q, state_d;
  logic [7:0] op_q, op_d, wdata_q, wdata_d, tx_byte_q, tx_byte_d;
  logic [2:0] hdr_q, hdr_d;
  logic [8:0] rem_q, rem_d;
  logic [1:0] lat_q, lat_d;
  logic [AW-1:0] addr_q, addr_d;
  logic transmit_q, transmit_d, tx_prev_q, mem_read_q, mem_read_d, mem_write_q, mem_write_d, error_q, error_d;
  logic expired, tx_ok;
  uart_mem_bridge_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk(clk), .rst_n(rst_n), .en(state_q == HDR || state_q == WR_DATA), .clr(received), .expired(expired)
  );
  // transmitter raises busy one cycle late, so also hold off for two cycles after our own strobe
  assign tx_ok = !is_transmitting && !transmit_q && !tx_prev_q;
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    hdr_d = hdr_q;
    rem_d = rem_q;
    lat_d = lat_q;
    addr_d = addr_q + AW'(mem_write_q | mem_read_q);
    wdata_d = wdata_q;
    tx_byte_d = tx_byte_q;
    transmit_d = 1'b0;
    mem_read_d = 1'b0;
    mem_write_d = 1'b0;
    error_d = 1'b0;
    case (state_q)
      IDLE: if (received) begin
        op_d = rx_byte;
        hdr_d = HDR_LEN;
        if (rx_byte == OP_READ || rx_byte == OP_WRITE || rx_byte == OP_FILL) state_d = HDR;
        else begin
          state_d = RESP;
          error_d = rx_byte != OP_PING;
        end
      end
      HDR: if (received) begin
        if (hdr_q == HDR_LEN) rem_d = {1'b0, rx_byte} + 9'd1;
        else addr_d = (addr_q << 8) | AW'(rx_byte);
        hdr_d = hdr_q - 3'd1;
        if (hdr_q == 3'd1) state_d = op_q == OP_READ ? RD_ISSUE : WR_DATA;
      end else if (expired) begin
        state_d = IDLE;
        error_d = 1'b1;
      end
      RD_ISSUE: if (tx_ok) begin
        mem_read_d = 1'b1;
        lat_d = 2'd0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        lat_d = lat_q + 2'd1;
        state_d = lat_q == LAT_END ? RD_SEND : RD_WAIT;
      end
      RD_SEND: begin
        transmit_d = 1'b1;
        tx_byte_d = mem_rdata;
        rem_d = rem_q - 9'd1;
        state_d = rem_q == 9'd1 ? IDLE : RD_ISSUE;
      end
      WR_DATA: if (received) begin
        wdata_d = rx_byte;
        mem_write_d = 1'b1;
        if (op_q == OP_FILL) state_d = FILL_RUN;
        else begin
          rem_d = rem_q - 9'd1;
          state_d = rem_q == 9'd1 ? RESP : WR_DATA;
        end
      end else if (expired) begin
        state_d = IDLE;
        error_d = 1'b1;
      end
      FILL_RUN: if (rem_q == 9'd1) state_d = RESP;
      else begin
        mem_write_d = 1'b1;
        rem_d = rem_q - 9'd1;
      end
      RESP: if (tx_ok) begin
        transmit_d = 1'b1;
        tx_byte_d = resp_byte(op_q);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      op_q <= '0;
      hdr_q <= '0;
      rem_q <= '0;
      lat_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      tx_byte_q <= '0;
      transmit_q <= 1'b0;
      tx_prev_q <= 1'b0;
      mem_read_q <= 1'b0;
      mem_write_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      hdr_q <= hdr_d;
      rem_q <= rem_d;
      lat_q <= lat_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      tx_byte_q <= tx_byte_d;
      transmit_q <= transmit_d;
      tx_prev_q <= transmit_q;
      mem_read_q <= mem_read_d;
      mem_write_q <= mem_write_d;
      error_q <= error_d;
    end
  assign transmit = transmit_q;
  assign tx_byte = tx_byte_q;
  assign mem_read = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr = addr_q;
  assign mem_wdata = wdata_q;
  assign busy = state_q != IDLE;
  assign error = error_q;
endmodule

// File: tb/tb_uart_mem_bridge.sv
// tb_uart_mem_bridge: directed scoreboard bench with UART busy model and latency-3 memory model
module tb_uart_mem_bridge;
  localparam int L = 3;
  logic clk = 0, rst_n = 0, received = 0, is_transmitting = 0;
  logic [7:0] rx_byte = 0, mem_rdata = 0, tx_byte, mem_wdata;
  logic transmit, mem_read, mem_write, busy, error;
  logic [15:0] mem_addr;
  logic [7:0] mem [0:65535];
  logic [7:0] pipe [0:L];
  logic [7:0] exp_tx [$];
  logic [23:0] exp_wr [$];
  int errors = 0, checks = 0, cyc = 0, rx_cyc = 0, rd_cyc = 0, busy_cnt = 0;
  int tx_seen = 0, err_pulses = 0, fill_n = 0, fill_first = 0, fill_last = 0;
  bit wr_timed = 0, rd_timed = 0, fill_mode = 0, free_tx = 0;

  uart_mem_bridge #(.ADDR_WIDTH(16), .MEM_LATENCY(L), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n), .received(received), .rx_byte(rx_byte),
    .is_transmitting(is_transmitting), .transmit(transmit), .tx_byte(tx_byte),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_transmit"}, transmit, 0);
    chk({tag, "_tx_byte"}, tx_byte, 0);
    chk({tag, "_mem_read"}, mem_read, 0);
    chk({tag, "_mem_write"}, mem_write, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte = b;
    received = 1;
    rx_cyc = cyc;
    @(negedge clk);
    received = 0;
    repeat (10) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (exp_tx.size() == 0 && exp_wr.size() == 0 && !busy) break;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_done"}, i < 3000, 1);
    chk({tag, "_tx_left"}, exp_tx.size(), 0);
    chk({tag, "_wr_left"}, exp_wr.size(), 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    logic [23:0] e;
    logic [7:0] t;
    forever begin
      @(negedge clk);
      is_transmitting = busy_cnt != 0;
      if (transmit) busy_cnt = 8;
      else if (busy_cnt != 0) busy_cnt--;
      if (error) err_pulses++;
      if (mem_read || mem_write) chk("rd_wr_excl", mem_read & mem_write, 0);
      if (mem_read) rd_cyc = cyc;
      for (int i = L; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = mem_read ? mem[mem_addr] : 8'hxx;
      mem_rdata = pipe[L];
      if (mem_write) begin
        mem[mem_addr] = mem_wdata;
        if (fill_mode) begin
          if (fill_n == 0) fill_first = cyc;
          fill_last = cyc;
          fill_n++;
        end
        if (wr_timed) chk("wr_lat", cyc - rx_cyc, 1);
        chk("wr_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          chk("wr_addr_data", {mem_addr, mem_wdata}, e);
        end
      end
      if (transmit) begin
        tx_seen++;
        if (!free_tx) begin
          if (rd_timed) chk("rd_lat", cyc - rd_cyc, L + 1);
          chk("tx_expected", exp_tx.size() != 0, 1);
          if (exp_tx.size() != 0) begin
            t = exp_tx.pop_front();
            chk("tx_byte", tx_byte, t);
          end
        end
      end
    end
  end

  initial begin
    int i, s, e0, d_cyc, t0;
    for (int k = 0; k < 65536; k++) mem[k] = k[7:0];
    for (int k = 0; k <= L; k++) pipe[k] = 0;
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1;
    repeat (2) @(negedge clk);

    wr_timed = 1;
    exp_wr.push_back({16'h1234, 8'hAA});
    exp_wr.push_back({16'h1235, 8'hBB});
    exp_wr.push_back({16'h1236, 8'hCC});
    exp_tx.push_back(8'hA5);
    foreach (exp_wr[k]) begin end
    send_byte(8'h02); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    drain("write");
    wr_timed = 0;

    rd_timed = 1;
    exp_tx.push_back(8'hAA); exp_tx.push_back(8'hBB); exp_tx.push_back(8'hCC);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h12); send_byte(8'h34);
    drain("read");
    rd_timed = 0;

    fill_mode = 1;
    fill_n = 0;
    for (int k = 0; k < 256; k++) exp_wr.push_back({16'(16'hFF80 + k), 8'h55});
    exp_tx.push_back(8'hA5);
    send_byte(8'h03); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h80);
    send_byte(8'h55);
    d_cyc = rx_cyc;
    drain("fill");
    fill_mode = 0;
    chk("fill_count", fill_n, 256);
    chk("fill_start", fill_first - d_cyc, 1);
    chk("fill_span", fill_last - fill_first, 255);
    chk("fill_wrap_end", mem[16'h007F], 8'h55);
    chk("fill_below_untouched", mem[16'hFF7F], 8'h7F);
    chk("fill_after_untouched", mem[16'h0080], 8'h80);

    e0 = err_pulses;
    exp_tx.push_back(8'hEE);
    send_byte(8'h07);
    drain("nak");
    chk("nak_error_pulses", err_pulses - e0, 1);
    exp_tx.push_back(8'h5A);
    send_byte(8'h04);
    drain("ping");
    chk("ping_no_error", err_pulses - e0, 1);

    e0 = err_pulses;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h40); send_byte(8'h00);
    s = rx_cyc;
    for (i = 0; i < 300; i++) begin
      @(negedge clk);
      if (error) break;
    end
    chk("to_fired", i < 300, 1);
    chk("to_latency_ok", (cyc - s) >= 100 && (cyc - s) <= 102, 1);
    repeat (20) @(negedge clk);
    chk("to_idle", busy, 0);
    chk("to_error_pulses", err_pulses - e0, 1);
    exp_wr.push_back({16'h4000, 8'h99});
    exp_tx.push_back(8'hA5);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h40); send_byte(8'h00);
    send_byte(8'h99);
    drain("after_to");

    free_tx = 1;
    t0 = tx_seen;
    send_byte(8'h01); send_byte(8'h09); send_byte(8'h20); send_byte(8'h00);
    for (i = 0; i < 500 && tx_seen < t0 + 2; i++) @(negedge clk);
    chk("midrst_progress", tx_seen >= t0 + 2, 1);
    @(negedge clk);
    #2 rst_n = 0;
    #1 check_reset("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1;
    t0 = tx_seen;
    repeat (80) @(negedge clk);
    chk("midrst_no_tx", tx_seen, t0);
    chk("midrst_idle", busy, 0);
    free_tx = 0;

    exp_tx.push_back(8'h5A);
    send_byte(8'h04);
    drain("ping2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
